// File: rtl/seg7_pkg.sv
// Shared encodings and the hex-to-segment table for the 4-digit scan driver.
// Optional build macro used by seg7_scan_driver: SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = DIGITS * NIB_W;
    localparam int unsigned OUT_W  = DIGITS + 8;

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_DRIVE = 1'b1;

    typedef enum logic {
        BLANK = ST_BLANK,
        DRIVE = ST_DRIVE
    } seg7_state_e;

    localparam logic [OUT_W-1:0] OUT_OFF = 12'hFFF;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-low {dp,g..a} segment byte.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_c_o
);

    assign seg_c_o = ~{dp_i, hex7(nibble_i)};

endmodule

// File: rtl/seg7_scan_driver.sv
// Tear-free 4-digit common-anode 7-segment scanner with per-slot dead time.
// Build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [11:0] out,
    output logic        frame_tick,
    output logic        pending
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    seg7_state_e       state_q, state_d;
    logic [DATA_W-1:0] shadow_q, active_q;
    logic [DIGITS-1:0] shadow_dp_q, active_dp_q;
    logic              pending_q;
    logic              tick_q;
    logic [OUT_W-1:0]  out_q, out_d;

    logic              cnt_last;
    logic              frame_end;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [7:0]        cur_seg;
    logic              lz_blank;

    seg7_hex_decode u_dec (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .seg_c_o  (cur_seg)
    );

    // Slot timing, state decode and the next pin pattern.
    always_comb begin
        cnt_last  = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
        frame_end = cnt_last && (idx_q == 2'd3);
        cnt_d     = cnt_last ? '0 : cnt_q + CNT_W'(1);
        idx_d     = cnt_last ? idx_q + 2'd1 : idx_q;
        state_d   = (cnt_d < CNT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;
        cur_nib   = active_q[{idx_q, 2'b00} +: 4];
        cur_dp    = active_dp_q[idx_q];
        lz_blank  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        unique case (idx_q)
            2'd1:    lz_blank = (active_q[15:4]  == 12'h000) && !active_dp_q[1];
            2'd2:    lz_blank = (active_q[15:8]  == 8'h00)   && !active_dp_q[2];
            2'd3:    lz_blank = (active_q[15:12] == 4'h0)    && !active_dp_q[3];
            default: lz_blank = 1'b0;
        endcase
`endif
        out_d = OUT_OFF;
        if (state_q == DRIVE) begin
            out_d = {~(4'b0001 << idx_q), lz_blank ? 8'hFF : cur_seg};
        end
    end

    // A write in the same cycle as a reload lands in the shadow and keeps pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            state_q     <= BLANK;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            tick_q      <= 1'b0;
            out_q       <= OUT_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            out_q   <= out_d;
            tick_q  <= frame_end;
            if (frame_end && pending_q) begin
                active_q    <= shadow_q;
                active_dp_q <= shadow_dp_q;
                pending_q   <= 1'b0;
            end
            if (wr_en) begin
                shadow_q    <= wr_data;
                shadow_dp_q <= wr_dp;
                pending_q   <= 1'b1;
            end
        end
    end

    assign out        = out_q;
    assign frame_tick = tick_q;
    assign pending    = pending_q;

endmodule
